// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and FSM encodings shared by the multiply/divide unit,
// its bus interface and anything that drives it.
package muldiv_pkg;

   // RV32M funct3 encoding; bit 2 selects divide, bit 1 selects remainder
   // within the divide group.
   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   // src_a is interpreted as two's complement
   function automatic logic op_a_signed(op_e op);
      return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
   endfunction

   // src_b is interpreted as two's complement
   function automatic logic op_b_signed(op_e op);
      return (op == MULH) || (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_div(op_e op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(op_e op);
      return op[2] && op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake of the multiply/divide unit.
// master = requester, slave = the unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
   import muldiv_pkg::*;

   logic            in_valid;
   logic            in_ready;
   op_e             op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] res;

   modport master (
      output in_valid, op, src_a, src_b, flush, out_ready,
      input  in_ready, out_valid, res
   );

   modport slave (
      input  in_valid, op, src_a, src_b, flush, out_ready,
      output in_ready, out_valid, res
   );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide. One radix-2 step per cycle
// over magnitudes, then a single sign-fix cycle. Divide-by-zero and signed
// overflow are resolved at accept time and skip the iteration entirely.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic           clk,
   input logic           reset,
   muldiv_unit_if.slave  bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_q, state_d;
   op_e                 op_q;
   logic                neg_q;
   logic [XLEN-1:0]     b_mag_q;
   logic [2*XLEN-1:0]   acc_q;     // {hi, lo}: product, or {remainder, quotient}
   logic [CW-1:0]       cnt_q;
   logic [XLEN-1:0]     res_q;

   // request decode
   logic                a_neg, b_neg, div_zero, div_ovf, bypass, neg_d;
   logic [XLEN-1:0]     a_mag, b_mag, bypass_res;

   // iteration / fix datapath
   logic [XLEN:0]       mul_sum, rem_sh, diff;
   logic                qbit;
   logic [2*XLEN-1:0]   acc_step, prod_fix;
   logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.res       = res_q;

   // Operand magnitudes, result sign and the short-cut divide cases
   always_comb begin
      a_neg      = op_a_signed(bus.op) && bus.src_a[XLEN-1];
      b_neg      = op_b_signed(bus.op) && bus.src_b[XLEN-1];
      a_mag      = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
      b_mag      = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
      // remainder follows the dividend; everything else the operand xor
      neg_d      = op_is_rem(bus.op) ? a_neg : (a_neg ^ b_neg);
      div_zero   = op_is_div(bus.op) && (bus.src_b == '0);
      div_ovf    = ((bus.op == DIV) || (bus.op == REM)) &&
                   (bus.src_a == MIN_NEG) && (bus.src_b == '1);
      bypass     = div_zero || div_ovf;
      bypass_res = '0;
      if (div_zero)
         bypass_res = op_is_rem(bus.op) ? bus.src_a : '1;
      else if (div_ovf)
         bypass_res = op_is_rem(bus.op) ? '0 : bus.src_a;
   end

   // One shift-add (mul) or restoring shift-subtract (div) step
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 (acc_q[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
      rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff     = rem_sh - {1'b0, b_mag_q};
      qbit     = ~diff[XLEN];
      if (op_is_div(op_q))
         acc_step = {(qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], qbit};
      else
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
   end

   // Sign correction and result select for the FIX cycle
   always_comb begin
      prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
      quot_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         MUL:                 fix_res = prod_fix[XLEN-1:0];
         MULH, MULHSU, MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         DIV, DIVU:           fix_res = quot_fix;
         default:             fix_res = rem_fix;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; flush wins over accept and out_ready
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) state_d = bypass ? DONE : CALC;
            CALC: if (cnt_q == LAST_CNT) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Operand capture, iteration and result register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q    <= MUL;
         neg_q   <= 1'b0;
         b_mag_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else if (bus.flush) begin
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  op_q    <= bus.op;
                  neg_q   <= neg_d;
                  b_mag_q <= b_mag;
                  acc_q   <= {{XLEN{1'b0}}, a_mag};
                  cnt_q   <= '0;
                  if (bypass) res_q <= bypass_res;
               end
            end
            CALC: begin
               acc_q <= acc_step;
               cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
            end
            FIX:  res_q <= fix_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table of directed vectors plus random traffic, expected
// results queued at accept and compared when out_valid appears; hand-written
// sequences for stall, flush and asynchronous reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;
   localparam int NLAT = XLEN + 2;

   typedef struct {
      op_e         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   vec_t tbl[$];
   exp_t sb[$];

   muldiv_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(op_e op, logic [31:0] a, logic [31:0] b);
      logic [63:0] p;
      int          sa, sb_;
      sa  = a;
      sb_ = b;
      case (op)
         MUL:    begin p = {32'b0, a} * {32'b0, b};             return p[31:0];  end
         MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
         MULHU:  begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
         DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return 32'(sa / sb_);
         end
         DIVU: begin
            if (b == 0) return 32'hFFFFFFFF;
            return a / b;
         end
         REM: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return 32'(sa % sb_);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int model_lat(op_e op, logic [31:0] a, logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == DIV || op == REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return NLAT;
   endfunction

   task automatic add(input op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      tbl.push_back(v);
   endtask

   // called at a negedge: present the request, push its expectation at accept
   task automatic drive_accept(input op_e op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int lat, input int hold);
      exp_t e;
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.src_a     = a;
      bus.src_b     = b;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      e.res = exp;
      e.lat = lat;
      sb.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // called at the first negedge after accept (cycle 1)
   task automatic collect(input int hold);
      exp_t got;
      int   n;
      n = 1;
      chk("busy_in_ready", bus.in_ready, 1'b0);
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) begin
         chk("out_valid_timeout", bus.out_valid, 1'b1);
         void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         chk("scoreboard_empty", 1'b1, 1'b0);
      end else begin
         got = sb.pop_front();
         chk("res", bus.res, got.res);
         chk("latency", n, got.lat);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_out_valid", bus.out_valid, 1'b1);
            chk("stall_res", bus.res, got.res);
            chk("stall_in_ready", bus.in_ready, 1'b0);
         end
         if (hold > 0) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            chk("release_in_ready", bus.in_ready, 1'b1);
            chk("release_out_valid", bus.out_valid, 1'b0);
         end
      end
   endtask

   task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int hold);
      @(negedge clk);
      chk("idle_in_ready", bus.in_ready, 1'b1);
      drive_accept(op, a, b, exp, lat, hold);
      collect(hold);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      n_cmp = 0;
      n_err = 0;
      bus.in_valid  = 1'b0;
      bus.op        = MUL;
      bus.src_a     = '0;
      bus.src_b     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      reset         = 1'b0;

      add(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, NLAT);
      add(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NLAT);
      add(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, NLAT);
      add(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, NLAT);
      add(MULH,   32'h80000000, 32'h80000000, 32'h40000000, NLAT);
      add(MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, NLAT);
      add(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      add(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      add(DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
      add(REMU,   32'd5,        32'd0,        32'd5,        1);
      add(DIV,    32'd0,        32'd0,        32'hFFFFFFFF, 1);
      add(REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
      add(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NLAT);
      add(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NLAT);
      add(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, NLAT);
      add(REM,    32'd7,        32'hFFFFFFFE, 32'd1,        NLAT);
      add(DIVU,   32'd100,      32'd7,        32'd14,       NLAT);
      add(REMU,   32'd100,      32'd7,        32'd2,        NLAT);
      add(DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, NLAT);
      add(REM,    32'h80000000, 32'd3,        32'hFFFFFFFE, NLAT);
      add(DIV,    32'h80000000, 32'd3,        32'hD5555556, NLAT);

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset_out_valid", bus.out_valid, 1'b0);
      chk("reset_in_ready",  bus.in_ready,  1'b1);
      chk("reset_res",       bus.res,       32'h0);

      // first accept on the first edge after reset release
      reset = 1'b1;
      drive_accept(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].exp, tbl[0].lat, 0);
      collect(0);
      for (int i = 1; i < tbl.size(); i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0);

      // consumer stalls five cycles in DONE, normal and bypass paths
      run_op(MUL,  32'h12345678, 32'h10, 32'h23456780, NLAT, 5);
      run_op(DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1, 5);

      // flush at CALC cycle 10: no result, then a normal op
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_in_ready",  bus.in_ready,  1'b1);
      chk("flush_out_valid", bus.out_valid, 1'b0);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) nv++;
      end
      chk("flush_no_result", nv, 0);
      run_op(DIVU, 32'd100, 32'd7, 32'd14, NLAT, 0);

      // flush beats accept in IDLE
      @(negedge clk);
      bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = MUL; bus.src_a = 32'd3; bus.src_b = 32'd3;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      chk("flush_vs_accept_ready", bus.in_ready,  1'b1);
      chk("flush_vs_accept_valid", bus.out_valid, 1'b0);

      // flush beats out_ready=0 in DONE
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.op = DIVU; bus.src_a = 32'd5; bus.src_b = 32'd0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("done_before_flush", bus.out_valid, 1'b1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      chk("flush_in_done_valid", bus.out_valid, 1'b0);
      chk("flush_in_done_ready", bus.in_ready,  1'b1);

      // random traffic against the behavioural model
      for (int i = 0; i < 40; i++) begin
         op_e         op;
         logic [31:0] a, b;
         op = op_e'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 7) == 0) b = 32'(b[3:0]);
         run_op(op, a, b, model(op, a, b), model_lat(op, a, b), (i % 9 == 0) ? 2 : 0);
      end

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = MULHU; bus.src_a = 32'hDEADBEEF; bus.src_b = 32'h1234;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_out_valid", bus.out_valid, 1'b0);
      chk("async_rst_in_ready",  bus.in_ready,  1'b1);
      chk("async_rst_res",       bus.res,       32'h0);
      @(negedge clk);
      reset = 1'b1;
      drive_accept(DIVU, 32'd100, 32'd7, 32'd14, NLAT, 0);
      collect(0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits (even, >= 8).
REQ-002 clk  in  1  rising-edge clock; single clock domain.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  request present on op/src_a/src_b.
REQ-005 in_ready  out  1  unit can accept a request this cycle.
REQ-006 op  in  3  operation, RV32M funct3 encoding from muldiv_pkg.
REQ-007 src_a  in  XLEN  multiplicand / dividend.
REQ-008 src_b  in  XLEN  multiplier / divisor.
REQ-009 flush  in  1  synchronous abort of any in-flight operation.
REQ-010 out_valid  out  1  res holds a completed result.
REQ-011 out_ready  in  1  consumer takes res this cycle.
REQ-012 res  out  XLEN  result.

Function
REQ-013 Ops SHALL be: MUL low XLEN of product; MULH/MULHSU/MULHU high XLEN of signed*signed, signed*unsigned, unsigned*unsigned; DIV/DIVU quotient truncated toward zero; REM/REMU remainder with dividend's sign.
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE; in_ready = 1 only in IDLE (state-decoded, no combinational path from in_valid).
REQ-015 Accept SHALL occur on an edge with in_valid && in_ready; operands and op latched, magnitudes taken for signed operands, state -> CALC.
REQ-016 CALC SHALL run exactly XLEN cycles, one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle, counter 0..XLEN-1, then -> FIX.
REQ-017 FIX SHALL apply sign correction (two's-complement negate of 2*XLEN product or of quotient/remainder as required), select res, -> DONE.
REQ-018 Normal latency: out_valid SHALL rise XLEN+2 cycles after the accept edge.
REQ-019 Divisor zero: DIV/DIVU res = all ones, REM/REMU res = src_a; signed overflow (DIV/REM, src_a = 1<<(XLEN-1), src_b = all ones): DIV res = src_a, REM res = 0; both SHALL bypass CALC/FIX, IDLE -> DONE, out_valid 1 cycle after accept.
REQ-020 In DONE out_valid SHALL stay 1 and res stable until out_ready; on out_valid && out_ready -> IDLE; no back-to-back accept in the same cycle.
REQ-021 flush SHALL force IDLE on the next edge from any state, drop out_valid, discard result; flush has priority over accept and out_ready.
REQ-022 res SHALL change only on the FIX -> DONE or IDLE -> DONE edge.
REQ-023 Internal product/remainder register SHALL be 2*XLEN bits; no overflow beyond it.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, out_valid = 0, res = 0, counter = 0, in_ready = 1, regardless of in-flight work.
REQ-025 First accept SHALL be possible on the first rising clk edge after reset deasserts.

Structure
REQ-026 muldiv_pkg SHALL hold the op enum (MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111) and the FSM state enum.
REQ-027 Single module, no sub-module; datapath and FSM in muldiv_unit.

Verification (XLEN=32)
REQ-028 MUL src_a=7, src_b=0xFFFFFFFD -> res 0xFFFFFFEB, out_valid exactly 34 cycles after accept.
REQ-029 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF,2 -> 0xFFFFFFFF.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, each out_valid 1 cycle after accept; DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF.
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_valid and res stable, in_ready 0; out_ready 1 -> in_ready 1 next cycle.
REQ-032 flush at CALC cycle 10 -> IDLE next edge, no out_valid; following DIVU 100/7 -> 14 with normal latency.
REQ-033 reset asserted mid-CALC, asynchronously between edges -> out_valid 0, in_ready 1 before next edge.
